// File: rtl/ps2_scan_decoder_pkg.sv
// Shared PS/2 decoder types: prefix bytes, frame-FSM states, key event layout
// and the 11-bit frame validity test.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    CHECK
  } frame_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  // Frame is stored with the start bit at [0]: start=0, stop=1, odd parity over data+parity.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [9:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [9:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [9:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_wr;
  logic        w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_rd   = i_rd_en && !o_empty;
  assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: pin sync, clock deglitch, 11-bit frame check,
// E0/F0 prefix folding into {code, ext, brk} events queued in a FWFT FIFO.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       idle
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  logic           r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic           r_filt_clk;
  logic [FCW-1:0] r_filt_cnt;
  frame_state_t   r_state, w_next;
  logic [10:0]    r_shift;
  logic [3:0]     r_bit_cnt;
  logic [TCW-1:0] r_to_cnt;
  logic           r_ext, r_brk;
  logic           r_frame_err, r_overflow;
  logic           w_fall, w_timeout, w_good, w_bad, w_push, w_pop;
  logic           w_full, w_empty;
  logic [7:0]     w_byte;
  ps2_event_t     w_ev, w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock flips only after FILTER_LEN consecutive samples of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FCW'(FILTER_LEN - 1)) begin
      r_filt_clk <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_fall    = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FCW'(FILTER_LEN - 1));
  assign w_timeout = (r_state == RX) && !w_fall && (r_to_cnt == TCW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_fall && !r_dat_s2) w_next = RX;
      RX: begin
        if (w_fall && (r_bit_cnt == 4'd10)) w_next = CHECK;
        else if (w_timeout)                  w_next = IDLE;
      end
      CHECK: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bits enter at the top and shift down, so the start bit ends at [0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == IDLE && w_fall && !r_dat_s2) begin
        r_shift   <= {r_dat_s2, r_shift[10:1]};
        r_bit_cnt <= 4'd1;
      end else if (r_state == RX && w_fall) begin
        r_shift   <= {r_dat_s2, r_shift[10:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == RX && !w_fall) r_to_cnt <= r_to_cnt + 1'b1;
      else                          r_to_cnt <= '0;
    end
  end

  assign w_byte = r_shift[8:1];
  assign w_good = (r_state == CHECK) && frame_ok(r_shift);
  assign w_bad  = (r_state == CHECK) && !frame_ok(r_shift);
  assign w_push = w_good && (w_byte != PS2_PREFIX_EXT) && (w_byte != PS2_PREFIX_BRK);
  assign w_pop  = key_ready && !w_empty;
  assign w_ev   = '{code: w_byte, ext: r_ext, brk: r_brk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_bad || w_timeout;
      r_overflow  <= w_push && w_full && !w_pop;
      if (w_bad || w_timeout) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (w_good) begin
        if (w_byte == PS2_PREFIX_EXT)      r_ext <= 1'b1;
        else if (w_byte == PS2_PREFIX_BRK) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_push),
    .i_wr_data(w_ev),
    .i_rd_en  (key_ready),
    .o_rd_data(w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign key_code  = w_head.code;
  assign key_ext   = w_head.ext;
  assign key_break = w_head.brk;
  assign key_valid = !w_empty;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign idle      = (r_state == IDLE);

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: bit-level PS/2 frames, popped events
// logged and compared with hand-computed {code, ext, brk} values.
module tb_ps2_scan_decoder;

  localparam int TO_CYC = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_ext, key_break, key_valid;
  logic       key_ready = 1'b0;
  logic       frame_err, overflow, idle;

  int checks = 0;
  int fails  = 0;
  int n_err  = 0;
  int n_ovf  = 0;
  logic [9:0] evq[$];

  always #5 clk = ~clk;

  ps2_scan_decoder #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(TO_CYC),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .frame_err(frame_err),
    .overflow (overflow),
    .idle     (idle)
  );

  always @(posedge clk) begin
    if (frame_err) n_err <= n_err + 1;
    if (overflow) n_ovf <= n_ovf + 1;
    if (key_valid && key_ready) evq.push_back({key_code, key_ext, key_break});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic expect_event(input string tag, input logic [7:0] code, input logic ext,
                              input logic brk);
    int n;
    logic [9:0] e;
    n = 0;
    while (evq.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = 'x;
    if (evq.size() != 0) e = evq.pop_front();
    check(tag, {22'd0, e}, {22'd0, code, ext, brk});
  endtask

  initial begin
    int e0, o0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_valid", key_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain make code
    key_ready = 1'b1;
    send_frame(8'h1C, 1'b0);
    expect_event("make_1C", 8'h1C, 1'b0, 1'b0);
    check("make_idle", idle, 1);
    check("make_noextra", evq.size(), 0);

    // Break code: F0 alone produces nothing
    send_frame(8'hF0, 1'b0);
    check("f0_noevent", evq.size(), 0);
    check("f0_novalid", key_valid, 0);
    send_frame(8'h1C, 1'b0);
    expect_event("brk_1C", 8'h1C, 1'b0, 1'b1);

    // Extended break
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_event("ext_brk_75", 8'h75, 1'b1, 1'b1);
    check("ext_noextra", evq.size(), 0);

    // Parity error clears a pending F0
    e0 = n_err;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b1);
    check("par_err_pulse", n_err - e0, 1);
    check("par_noevent", evq.size(), 0);
    send_frame(8'h1C, 1'b0);
    expect_event("after_err_1C", 8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_event("after_err_brk", 8'h1C, 1'b0, 1'b1);

    // Timeout on partial frame
    e0 = n_err;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    check("to_busy", idle, 0);
    repeat (TO_CYC + 100) @(negedge clk);
    check("to_err_pulse", n_err - e0, 1);
    check("to_idle", idle, 1);
    check("to_noevent", evq.size(), 0);
    send_frame(8'h1C, 1'b0);
    expect_event("after_to_1C", 8'h1C, 1'b0, 1'b0);

    // Overflow
    key_ready = 1'b0;
    o0 = n_ovf;
    for (int c = 8'h15; c <= 8'h18; c++) send_frame(c[7:0], 1'b0);
    check("full_no_ovf", n_ovf - o0, 0);
    send_frame(8'h19, 1'b0);
    check("ovf_pulse", n_ovf - o0, 1);
    check("ovf_head_valid", key_valid, 1);
    check("ovf_head_code", key_code, 8'h15);
    @(negedge clk);
    key_ready = 1'b1;
    expect_event("drain_15", 8'h15, 1'b0, 1'b0);
    expect_event("drain_16", 8'h16, 1'b0, 1'b0);
    expect_event("drain_17", 8'h17, 1'b0, 1'b0);
    expect_event("drain_18", 8'h18, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check("drain_empty", evq.size(), 0);
    check("drain_novalid", key_valid, 0);

    // Reset mid-frame with an event pending
    key_ready = 1'b0;
    send_frame(8'h1C, 1'b0);
    check("pend_valid", key_valid, 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    check("mid_busy", idle, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_idle", idle, 1);
    check("mid_rst_valid", key_valid, 0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    key_ready = 1'b1;
    send_frame(8'h1C, 1'b0);
    expect_event("post_rst_1C", 8'h1C, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
